// File: rtl/game_pkg.sv
// Shared types for the game sequencer: screen-mode state encoding and helpers.
package game_pkg;

    typedef enum logic [2:0] {
        ST_START,
        ST_PLAY,
        ST_PAUSE,
        ST_OVER,
        ST_FINISH
    } game_state_t;

    // End screens share the start-button hold-off behaviour.
    function automatic logic is_end_screen(input game_state_t s);
        return (s == ST_OVER) || (s == ST_FINISH);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw button to single-cycle press pulse: 2-FF synchroniser, run-length
// debounce against the accepted level, and rising-edge detect.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          db_q;
    logic          db_d;
    logic          db_prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The accepted level only moves after the synchronised level has
    // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            meta_q    <= btn_i;
            sync_q    <= meta_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    assign press_o = db_q & ~db_prev_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: turns start/pause buttons and crash/goal events into
// registered screen-mode enables, pause level and a timer-restart pulse.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int HOLD_FRAMES     = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic refresh_tick,
    input  logic btn_start,
    input  logic btn_pause,
    input  logic crash,
    input  logic goal,
    output logic start_en,
    output logic over_en,
    output logic finish_en,
    output logic pause,
    output logic play_en,
    output logic timer_clr
);

    localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    logic [1:0]    btn_raw;
    logic [1:0]    btn_press;
    logic          start_press;
    logic          pause_press;
    game_state_t   state_q;
    game_state_t   state_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic          timer_clr_d;

    assign btn_raw = {btn_pause, btn_start};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset  (reset),
                .btn_i  (btn_raw[gi]),
                .press_o(btn_press[gi])
            );
        end
    endgenerate

    assign start_press = btn_press[0];
    assign pause_press = btn_press[1];

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_START: begin
                if (start_press) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (crash)            state_d = ST_OVER;
                else if (goal)        state_d = ST_FINISH;
                else if (pause_press) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (pause_press) state_d = ST_PLAY;
            end
            ST_OVER, ST_FINISH: begin
                // A press during the hold-off is dropped, not remembered.
                if (start_press && hold_q == '0) begin
                    state_d = ST_PLAY;
                end else if (refresh_tick && hold_q != '0) begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = ST_START;
        endcase
        if (is_end_screen(state_d) && !is_end_screen(state_q)) begin
            hold_d = HW'(HOLD_FRAMES);
        end
    end

    // Resuming from PAUSE keeps the running timer.
    assign timer_clr_d = (state_d == ST_PLAY) && (state_q != ST_PLAY) &&
                         (state_q != ST_PAUSE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_START;
            hold_q    <= '0;
            start_en  <= 1'b1;
            over_en   <= 1'b0;
            finish_en <= 1'b0;
            play_en   <= 1'b0;
            pause     <= 1'b1;
            timer_clr <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            start_en  <= (state_d == ST_START);
            over_en   <= (state_d == ST_OVER);
            finish_en <= (state_d == ST_FINISH);
            play_en   <= (state_d == ST_PLAY);
            pause     <= (state_d != ST_PLAY);
            timer_clr <= timer_clr_d;
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios plus random stimulus,
// checked every cycle against a behavioural model of the game rules.
module tb_game_state_ctrl;

    localparam int DB = 4;
    localparam int HF = 3;

    localparam int M_START  = 0;
    localparam int M_PLAY   = 1;
    localparam int M_PAUSE  = 2;
    localparam int M_OVER   = 3;
    localparam int M_FINISH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic refresh_tick = 1'b0;
    logic btn_start = 1'b0;
    logic btn_pause = 1'b0;
    logic crash = 1'b0;
    logic goal = 1'b0;
    logic start_en, over_en, finish_en, pause, play_en, timer_clr;

    int checks = 0;
    int errors = 0;

    game_state_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_FRAMES    (HF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .refresh_tick(refresh_tick),
        .btn_start   (btn_start),
        .btn_pause   (btn_pause),
        .crash       (crash),
        .goal        (goal),
        .start_en    (start_en),
        .over_en     (over_en),
        .finish_en   (finish_en),
        .pause       (pause),
        .play_en     (play_en),
        .timer_clr   (timer_clr)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw button -> two-cycle delay line, then a level
    // that flips once the delayed level has disagreed for DB cycles.
    int m_state = M_START;
    int m_hold = 0;
    bit m_clr = 1'b0;
    bit m_valid = 1'b0;
    bit m_meta[2];
    bit m_sync[2];
    bit m_db[2];
    bit m_dbp[2];
    int m_run[2];

    always @(posedge clk) begin : model
        bit ps;
        bit pp;
        bit raw[2];
        int prev;
        raw[0] = btn_start;
        raw[1] = btn_pause;
        m_valid = 1'b1;
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                m_meta[b] = 0; m_sync[b] = 0; m_db[b] = 0; m_dbp[b] = 0; m_run[b] = 0;
            end
            m_state = M_START;
            m_hold  = 0;
            m_clr   = 0;
        end else begin
            ps = m_db[0] && !m_dbp[0];
            pp = m_db[1] && !m_dbp[1];
            for (int b = 0; b < 2; b++) begin
                m_dbp[b] = m_db[b];
                if (m_sync[b] != m_db[b]) begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == DB) begin
                        m_db[b]  = m_sync[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_sync[b] = m_meta[b];
                m_meta[b] = raw[b];
            end
            prev  = m_state;
            m_clr = 0;
            if (prev == M_START) begin
                if (ps) begin m_state = M_PLAY; m_clr = 1; end
            end else if (prev == M_PLAY) begin
                if (crash)     begin m_state = M_OVER;   m_hold = HF; end
                else if (goal) begin m_state = M_FINISH; m_hold = HF; end
                else if (pp)   m_state = M_PAUSE;
            end else if (prev == M_PAUSE) begin
                if (pp) m_state = M_PLAY;
            end else begin
                if (ps && m_hold == 0) begin
                    m_state = M_PLAY;
                    m_clr   = 1;
                end else if (refresh_tick && m_hold > 0) begin
                    m_hold = m_hold - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            cmp("start_en",  start_en,  m_state == M_START);
            cmp("over_en",   over_en,   m_state == M_OVER);
            cmp("finish_en", finish_en, m_state == M_FINISH);
            cmp("play_en",   play_en,   m_state == M_PLAY);
            cmp("pause",     pause,     m_state != M_PLAY);
            cmp("timer_clr", timer_clr, m_clr);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        refresh_tick = 1'b1;
        cyc(1);
        refresh_tick = 1'b0;
        cyc(2);
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        cyc(10);
        btn_start = 1'b0;
        cyc(10);
    endtask

    task automatic press_pause();
        btn_pause = 1'b1;
        cyc(10);
        btn_pause = 1'b0;
        cyc(10);
    endtask

    initial begin : stim
        int sr;
        int pr;
        sr = 0;
        pr = 0;

        cyc(3);
        reset = 1'b0;
        cyc(10);
        cmp("idle_start_en", start_en, 1'b1);
        cmp("idle_pause",    pause,    1'b1);
        cmp("idle_play_en",  play_en,  1'b0);

        // Start press: raw high ahead of edge k, PLAY lands at edge k+6.
        btn_start = 1'b1;
        cyc(6);
        cmp("start_k5_play_en", play_en, 1'b0);
        cyc(1);
        cmp("start_k6_play_en",   play_en,   1'b1);
        cmp("start_k6_timer_clr", timer_clr, 1'b1);
        cyc(1);
        cmp("start_k7_timer_clr", timer_clr, 1'b0);
        cyc(12);
        btn_start = 1'b0;
        cyc(10);

        // Bounces of 3 cycles must not be accepted.
        repeat (5) begin
            btn_pause = 1'b1;
            cyc(3);
            btn_pause = 1'b0;
            cyc(1);
        end
        cyc(8);
        cmp("bounce_play_en", play_en, 1'b1);
        press_pause();
        cmp("paused_pause",   pause,   1'b1);
        cmp("paused_play_en", play_en, 1'b0);
        cmp("paused_start_en", start_en, 1'b0);
        press_pause();
        cmp("resume_play_en", play_en, 1'b1);

        // Crash beats goal.
        crash = 1'b1;
        goal  = 1'b1;
        cyc(1);
        crash = 1'b0;
        goal  = 1'b0;
        cmp("crash_over_en",   over_en,   1'b1);
        cmp("crash_finish_en", finish_en, 1'b0);
        repeat (3) tick_once();
        press_start();
        cmp("over_exit_play_en", play_en, 1'b1);

        goal = 1'b1;
        cyc(1);
        goal = 1'b0;
        cmp("goal_finish_en", finish_en, 1'b1);
        repeat (2) tick_once();
        press_start();
        cmp("hold_finish_en", finish_en, 1'b1);
        cmp("hold_play_en",   play_en,   1'b0);
        tick_once();
        press_start();
        cmp("finish_exit_play_en", play_en, 1'b1);

        // Reset during PAUSE with a start press mid-debounce.
        press_pause();
        cmp("pre_reset_pause", pause, 1'b1);
        btn_start = 1'b1;
        cyc(3);
        reset     = 1'b1;
        btn_start = 1'b0;
        cyc(1);
        reset = 1'b0;
        cmp("reset_start_en",  start_en,  1'b1);
        cmp("reset_timer_clr", timer_clr, 1'b0);
        cyc(12);
        cmp("reset_drop_start_en", start_en, 1'b1);
        cmp("reset_drop_play_en",  play_en,  1'b0);

        for (int i = 0; i < 4000; i++) begin
            if (sr == 0) begin
                btn_start = 1'($urandom_range(0, 1));
                sr = $urandom_range(1, 12);
            end
            if (pr == 0) begin
                btn_pause = 1'($urandom_range(0, 1));
                pr = $urandom_range(1, 12);
            end
            sr--;
            pr--;
            crash        = ($urandom_range(0, 29) == 0);
            goal         = ($urandom_range(0, 29) == 0);
            refresh_tick = ($urandom_range(0, 3) == 0);
            reset        = ($urandom_range(0, 599) == 0);
            cyc(1);
        end
        reset = 1'b0;
        crash = 1'b0;
        goal  = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Top-level game sequencer for the VGA game. Converts raw start/pause buttons and crash/goal events from the game logic into the screen-mode enables (`start_en`, `over_en`, `finish_en`) and the `pause` level consumed by the text overlay, plus a one-cycle `timer_clr` that restarts the on-screen timer. It sits directly upstream of the text overlay and the playfield renderer. It is a registered Moore FSM with per-button synchroniser and debounce and a frame-based hold-off after end screens.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250_000: consecutive clk cycles a synchronised button level must differ from the debounced level before it is accepted. Minimum 1.
- `HOLD_FRAMES`, default 60: `refresh_tick` pulses after entering OVER/FINISH during which `btn_start` is ignored. 0 means no hold.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: system/pixel clock.
- `reset` input 1: synchronous, active-high.
- `refresh_tick` input 1: one-cycle pulse per frame.
- `btn_start` input 1: raw asynchronous button, active-high.
- `btn_pause` input 1: raw asynchronous button, active-high.
- `crash` input 1: synchronous to `clk`, sampled as a level.
- `goal` input 1: synchronous to `clk`, sampled as a level.
- `start_en` output 1: start screen active.
- `over_en` output 1: game-over screen active.
- `finish_en` output 1: finish screen active.
- `pause` output 1: timer/world frozen; high in every state except PLAY.
- `play_en` output 1: high only in PLAY.
- `timer_clr` output 1: one-cycle pulse on every entry into PLAY from START, OVER or FINISH.

## Operation
- Button path, per button:
  - 2-FF synchroniser, giving `btn_s`.
  - Debounce counter: increments each cycle while `btn_s != db`. It clears when they are equal.
  - When the count reaches `DEBOUNCE_CYCLES-1` with `btn_s != db` still true: `db <= btn_s` and the counter clears.
  - `press = db & ~db_d`, a single cycle per accepted rising edge. Releases generate nothing.
- States: START, PLAY, PAUSE, OVER, FINISH. Reset state is START.
- START: `start_press` → PLAY, with `timer_clr`. All other inputs are ignored.
- PLAY, priority crash > goal > pause:
  - `crash` → OVER.
  - `goal` → FINISH.
  - `pause_press` → PAUSE.
  - `start_press` is ignored.
- PAUSE:
  - `pause_press` → PLAY. No `timer_clr`.
  - `crash`, `goal` and `start_press` are ignored.
- OVER / FINISH:
  - On entry the hold counter loads `HOLD_FRAMES`.
  - The counter decrements on each `refresh_tick` while non-zero and saturates at 0.
  - `start_press` with hold == 0 → PLAY with `timer_clr`.
  - `start_press` with hold != 0 is discarded, not queued.
  - `pause_press`, `crash` and `goal` are ignored.
- Output decode, registered from the next state so outputs align with the state register:
  - `start_en` = START.
  - `over_en` = OVER.
  - `finish_en` = FINISH.
  - `play_en` = PLAY.
  - `pause` = !PLAY.
  - Exactly one of `start_en`/`over_en`/`finish_en`/`play_en` is high, except in PAUSE, where all four are low and `pause` is 1.
- Hold counter width is `$clog2(HOLD_FRAMES+1)`, minimum 1 bit. Debounce counter width is `$clog2(DEBOUNCE_CYCLES)`, minimum 1 bit.

## Timing
- Reset values:
  - state START; `start_en`=1, `pause`=1.
  - `over_en`, `finish_en`, `play_en`, `timer_clr` = 0.
  - Synchronisers, debounced levels and counters = 0.
  - Hold counter = 0.
- Reset asserted mid-game forces the reset values on the next edge, from any state.
- Button latency:
  - Raw button high before edge k gives `db` high after edge k+1+`DEBOUNCE_CYCLES`.
  - `press` is combinational on `db`.
  - State and outputs update at edge k+2+`DEBOUNCE_CYCLES`.
  - The same-edge `timer_clr` pulse is high for exactly that cycle.
- `crash`/`goal` high in the cycle before edge k gives the new state/outputs after edge k (1-cycle latency).
- `refresh_tick` in the same cycle as entry into OVER/FINISH does not decrement; the load wins.
- Bounces shorter than `DEBOUNCE_CYCLES` cycles produce no press.
- A button held down produces exactly one press.

## Structure
- Shared package `game_pkg` holds:
  - `typedef enum logic [2:0] game_state_t {ST_START, ST_PLAY, ST_PAUSE, ST_OVER, ST_FINISH}`.
  - Color/default constants, if added later.
- Sub-module `button_debounce` (synchroniser, debounce counter, rising-edge pulse), instantiated twice and parameterised by `DEBOUNCE_CYCLES`.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4 and `HOLD_FRAMES`=3.
- Reset release, no input → `start_en`=1, `pause`=1, `play_en`=0, held indefinitely.
- `btn_start` raw high held 20 cycles, first sampled at edge k → `play_en` rises and `timer_clr`=1 exactly at edge k+6. Only one `timer_clr` pulse.
- Bouncing `btn_pause` in PLAY (high 3 cycles, low 1, repeated 5×) → no state change. Then a steady high → PAUSE, `pause`=1, no `timer_clr`. A second press → PLAY, no `timer_clr`.
- In PLAY, `crash`=1 and `goal`=1 in the same cycle → OVER next edge, `over_en`=1, `finish_en`=0.
- In FINISH: `btn_start` press after 2 `refresh_tick`s → ignored. Press after a 3rd tick → PLAY with `timer_clr`.
- Reset asserted one cycle while in PAUSE → START with reset values next edge. A `btn_start` press already in debounce is discarded.
